// File: rtl/sum_deserializer_pkg.sv
// Shared types and defaults for the serial-adder receive path.
package sum_deserializer_pkg;
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } sd_state_e;

  localparam int SD_WIDTH_DEF = 8;
endpackage

// File: rtl/sum_deserializer.sv
// Assembles the LSB-first sum/carry bit stream into a WIDTH-bit word and
// presents it through a single valid/ready holding register.
import sum_deserializer_pkg::*;

module sum_deserializer #(
  parameter int WIDTH = SD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             frame_err,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH + 1);

  sd_state_e        r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_out_valid, r_out_carry, r_frame_err, r_overrun;
  logic [WIDTH-1:0] r_out_data;

  logic             w_accept, w_complete, w_abort;
  logic [CW-1:0]    w_pos;
  logic [WIDTH-1:0] w_shift_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // A qualified in_first always restarts the frame at bit 0, from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = in_valid & (in_first | (r_state == COLLECT));
    w_abort     = in_valid & in_first & (r_state == COLLECT);
    w_pos       = (in_valid & in_first) ? '0 : r_cnt;
    w_complete  = w_accept & (w_pos == CW'(WIDTH - 1));
    w_shift_nxt = in_first ? '0 : r_shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_pos == CW'(i)) w_shift_nxt[i] = in_sum;
    end
    if (w_accept) w_state_nxt = w_complete ? IDLE : COLLECT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      if (w_accept) begin
        r_shift <= w_shift_nxt;
        r_cnt   <= w_complete ? '0 : w_pos + CW'(1);
      end
      // A full, unaccepted holder wins: the new word is dropped and flagged.
      if (w_complete && r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end else if (w_complete) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_shift_nxt;
        r_out_carry <= in_carry;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_carry = r_out_carry;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_sum_deserializer.sv
// Directed bench for sum_deserializer with an expected-word scoreboard.
module tb_sum_deserializer;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_first, in_sum, in_carry, out_ready;
  logic       out_valid, out_carry, frame_err, overrun;
  logic [7:0] out_data;

  logic       d1_valid, d1_first, d1_sum, d1_carry;
  logic       d1_out_valid, d1_out_carry, d1_frame_err, d1_overrun;
  logic [0:0] d1_out_data;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  sum_deserializer #(.WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
    .frame_err(frame_err), .overrun(overrun)
  );

  sum_deserializer #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(d1_valid), .in_first(d1_first),
    .in_sum(d1_sum), .in_carry(d1_carry), .out_valid(d1_out_valid),
    .out_ready(1'b1), .out_data(d1_out_data), .out_carry(d1_out_carry),
    .frame_err(d1_frame_err), .overrun(d1_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic f, input logic s, input logic c);
    in_valid = 1'b1; in_first = f; in_sum = s; in_carry = c;
    tick();
    in_valid = 1'b0; in_first = 1'b0; in_sum = 1'b0; in_carry = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic c, input bit push, input int stall_after);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && push) q.push_back({c, d});
      send_bit(i == 0, d[i], (i == 7) ? c : 1'b0);
      if (i == stall_after) repeat (3) tick();
    end
  endtask

  // Scoreboard: every handshake pops one expected {carry,data}.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) fe_cnt++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL spurious_word observed=%0h expected=none", {out_carry, out_data});
        end else begin
          chk("word", {23'd0, out_carry, out_data}, {23'd0, q.pop_front()});
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 0; in_first = 0; in_sum = 0; in_carry = 0; out_ready = 1;
    d1_valid = 0; d1_first = 0; d1_sum = 0; d1_carry = 0;
    repeat (2) tick();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    chk("rst_carry", {31'd0, out_carry}, 0);
    chk("rst_ferr", {31'd0, frame_err}, 0);
    chk("rst_ovr", {31'd0, overrun}, 0);
    reset = 1'b0;
    tick();

    // Bit without in_first in IDLE is ignored.
    send_bit(1'b0, 1'b1, 1'b1);
    chk("idle_ignore_valid", {31'd0, out_valid}, 0);

    // Basic frame 0xA5, carry 1.
    send_frame(8'hA5, 1'b1, 1, -1);
    chk("a5_valid", {31'd0, out_valid}, 1);
    chk("a5_data", {24'd0, out_data}, 32'hA5);
    chk("a5_carry", {31'd0, out_carry}, 1);
    tick();
    chk("a5_drained", {31'd0, out_valid}, 0);

    // Same frame stalled 3 cycles mid-frame.
    send_frame(8'hA5, 1'b1, 1, 3);
    chk("stall_valid", {31'd0, out_valid}, 1);
    chk("stall_data", {24'd0, out_data}, 32'hA5);
    tick();
    chk("no_ferr_yet", fe_cnt, 0);

    // Abort after 4 bits, then 0x3C.
    for (int i = 0; i < 4; i++) send_bit(i == 0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1, -1);
    chk("abort_data", {24'd0, out_data}, 32'h3C);
    chk("abort_carry", {31'd0, out_carry}, 0);
    tick();
    chk("abort_ferr_pulses", fe_cnt, 1);

    // Overrun: hold 0x11, drop 0x22.
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    tick();
    chk("ovr_valid", {31'd0, out_valid}, 1);
    chk("ovr_data_held", {24'd0, out_data}, 32'h11);
    chk("ovr_carry_held", {31'd0, out_carry}, 0);
    chk("ovr_flag", {31'd0, overrun}, 1);
    out_ready = 1'b1;
    tick();
    chk("ovr_drained", {31'd0, out_valid}, 0);
    chk("ovr_sticky", {31'd0, overrun}, 1);

    // Back-to-back 0xFF, 0x00 with no gap.
    send_frame(8'hFF, 1'b1, 1, -1);
    chk("b2b_first", {24'd0, out_data}, 32'hFF);
    send_frame(8'h00, 1'b0, 1, -1);
    chk("b2b_second_valid", {31'd0, out_valid}, 1);
    chk("b2b_second", {24'd0, out_data}, 32'h00);
    tick();
    chk("b2b_no_ferr", fe_cnt, 1);

    // Reset mid-frame discards partial word and clears overrun.
    for (int i = 0; i < 5; i++) send_bit(i == 0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_ovr", {31'd0, overrun}, 0);
    send_frame(8'h81, 1'b0, 1, -1);
    chk("r81_data", {24'd0, out_data}, 32'h81);
    tick();

    // WIDTH=1: every first-qualified bit is a full word.
    d1_valid = 1; d1_first = 1; d1_sum = 1; d1_carry = 1;
    tick();
    chk("w1_valid_a", {31'd0, d1_out_valid}, 1);
    chk("w1_data_a", {31'd0, d1_out_data}, 1);
    chk("w1_carry_a", {31'd0, d1_out_carry}, 1);
    d1_first = 0; d1_sum = 0; d1_carry = 0;
    tick();
    chk("w1_ignored", {31'd0, d1_out_valid}, 0);
    d1_first = 1;
    tick();
    chk("w1_valid_b", {31'd0, d1_out_valid}, 1);
    chk("w1_data_b", {31'd0, d1_out_data}, 0);
    d1_valid = 0; d1_first = 0;
    tick();
    chk("w1_ferr", {31'd0, d1_frame_err}, 0);
    chk("w1_ovr", {31'd0, d1_overrun}, 0);

    tick();
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
